// File: rtl/ex_stage.sv
// Execute stage: operand bypass select, add/li/ld issue, iterative shift-add multiply.
// Latency: add/li/ld 1 cycle; mul 16/BITS_PER_CYCLE busy cycles, then a one-cycle we_q.
// Backpressure: busy is high while multiplying; load is ignored until busy falls.
module ex_stage #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        load,
    input  logic [15:0] ir,
    input  logic [15:0] rs1_data,
    input  logic [15:0] rs2_data,
    input  logic        fwd_sr1,
    input  logic        fwd_sr2,
    input  logic        fwd_sr1_dr,
    input  logic        fwd_sr2_dr,
    input  logic [15:0] load_data,
    output logic [15:0] result_q,
    output logic [2:0]  dr_q,
    output logic        we_q,
    output logic [15:0] mem_addr_q,
    output logic        mem_re_q,
    output logic        busy
);

    localparam int N = 16 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state, state_d;
    logic [15:0] mcand, mcand_d;
    logic [15:0] mplier, mplier_d;
    logic [15:0] acc, acc_d;
    logic [4:0]  cnt, cnt_d;
    logic [15:0] result_d, mem_addr_d;
    logic [2:0]  dr_d;
    logic        we_d, mem_re_d, busy_d;

    logic [15:0] op_a, op_b, step_sum;
    logic        is_ld, is_add, is_mul, is_li;

    assign is_ld  = (ir[15:14] == 2'b00) && (ir[7:0] == 8'h01);
    assign is_add = (ir[15:14] == 2'b00) && (ir[4:0] == 5'b00010);
    assign is_mul = (ir[15:14] == 2'b00) && (ir[4:0] == 5'b00011);
    assign is_li  = (ir[15:14] == 2'b01) && (ir[10:8] == 3'b000);

    // Load-data bypass takes priority over the ALU-result bypass.
    always_comb begin
        op_a = fwd_sr1_dr ? load_data : (fwd_sr1 ? result_q : rs1_data);
        op_b = fwd_sr2_dr ? load_data : (fwd_sr2 ? result_q : rs2_data);
    end

    always_comb begin
        step_sum = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                step_sum = step_sum + (mcand << i);
            end
        end
    end

    always_comb begin
        state_d    = state;
        mcand_d    = mcand;
        mplier_d   = mplier;
        acc_d      = acc;
        cnt_d      = cnt;
        result_d   = result_q;
        dr_d       = dr_q;
        mem_addr_d = mem_addr_q;
        we_d       = 1'b0;
        mem_re_d   = 1'b0;
        busy_d     = busy;
        case (state)
            IDLE: begin
                if (load) begin
                    if (is_add) begin
                        result_d = op_a + op_b;
                        dr_d     = ir[13:11];
                        we_d     = 1'b1;
                    end else if (is_li) begin
                        result_d = {{8{ir[7]}}, ir[7:0]};
                        dr_d     = ir[13:11];
                        we_d     = 1'b1;
                    end else if (is_ld) begin
                        mem_addr_d = op_a;
                        mem_re_d   = 1'b1;
                        dr_d       = ir[13:11];
                    end else if (is_mul) begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        acc_d    = 16'h0000;
                        cnt_d    = 5'd0;
                        busy_d   = 1'b1;
                        dr_d     = ir[13:11];
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                acc_d    = step_sum;
                mcand_d  = mcand << BITS_PER_CYCLE;
                mplier_d = mplier >> BITS_PER_CYCLE;
                cnt_d    = cnt + 5'd1;
                if (cnt == CNT_LAST) begin
                    result_d = step_sum;
                    we_d     = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            mcand      <= 16'h0000;
            mplier     <= 16'h0000;
            acc        <= 16'h0000;
            cnt        <= 5'd0;
            result_q   <= 16'h0000;
            dr_q       <= 3'd0;
            we_q       <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_re_q   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            mcand      <= mcand_d;
            mplier     <= mplier_d;
            acc        <= acc_d;
            cnt        <= cnt_d;
            result_q   <= result_d;
            dr_q       <= dr_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_re_q   <= mem_re_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand sequences for mul and reset.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        load;
    logic [15:0] ir, rs1_data, rs2_data, load_data;
    logic        fwd_sr1, fwd_sr2, fwd_sr1_dr, fwd_sr2_dr;
    logic [15:0] result_q, mem_addr_q, result4_q, mem_addr4_q;
    logic [2:0]  dr_q, dr4_q;
    logic        we_q, mem_re_q, busy, we4_q, mem_re4_q, busy4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    ex_stage #(.BITS_PER_CYCLE(1)) dut (
        .CLK(CLK), .RSTN(RSTN), .load(load), .ir(ir),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_sr1(fwd_sr1), .fwd_sr2(fwd_sr2),
        .fwd_sr1_dr(fwd_sr1_dr), .fwd_sr2_dr(fwd_sr2_dr),
        .load_data(load_data), .result_q(result_q), .dr_q(dr_q), .we_q(we_q),
        .mem_addr_q(mem_addr_q), .mem_re_q(mem_re_q), .busy(busy)
    );

    ex_stage #(.BITS_PER_CYCLE(4)) dut4 (
        .CLK(CLK), .RSTN(RSTN), .load(load), .ir(ir),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_sr1(fwd_sr1), .fwd_sr2(fwd_sr2),
        .fwd_sr1_dr(fwd_sr1_dr), .fwd_sr2_dr(fwd_sr2_dr),
        .load_data(load_data), .result_q(result4_q), .dr_q(dr4_q), .we_q(we4_q),
        .mem_addr_q(mem_addr4_q), .mem_re_q(mem_re4_q), .busy(busy4)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] rs1;
        logic [15:0] rs2;
        logic        f1, f2, f1dr, f2dr;
        logic [15:0] ldat;
        logic [15:0] exp_res;
        logic [2:0]  exp_dr;
        logic        exp_we;
        logic        exp_re;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; ir = 16'h0000; rs1_data = 16'h0000; rs2_data = 16'h0000;
        fwd_sr1 = 1'b0; fwd_sr2 = 1'b0; fwd_sr1_dr = 1'b0; fwd_sr2_dr = 1'b0;
        load_data = 16'h0000;
    endtask

    // ir 0x3143: mul dr=6, sr1=1, sr2=2
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input logic [15:0] prev_res);
        int cyc, cyc4;
        logic done;
        idle_inputs();
        ir = 16'h3143; rs1_data = a; rs2_data = b; load = 1'b1;
        step();
        cyc = 0; cyc4 = 0; done = 1'b0;
        while (busy && cyc < 40) begin
            cyc++;
            if (busy4) cyc4++;
            check("mul_we_during_busy", {15'd0, we_q}, 16'h0000);
            check("mul_result_hold", result_q, prev_res);
            // stray issue attempts while busy must be ignored
            ir = 16'h0902; rs1_data = 16'h0055; rs2_data = 16'h0011;
            load = cyc[0];
            step();
        end
        load = 1'b0;
        check("mul_busy_cycles", 16'(cyc), 16'd16);
        check("mul4_busy_cycles", 16'(cyc4), 16'd4);
        check("mul_result", result_q, exp);
        check("mul_dr", {13'd0, dr_q}, 16'd6);
        check("mul_we_pulse", {15'd0, we_q}, 16'd1);
        step();
        check("mul_we_drop", {15'd0, we_q}, 16'd0);
        check("mul_result_after", result_q, exp);
    endtask

    initial begin
        //        ir       rs1      rs2      f1 f2 f1d f2d ldat     res      dr we re addr
        vecs[0]  = '{16'h0902, 16'h0003, 16'h0004, 0, 0, 0, 0, 16'h0000, 16'h0007, 1, 1, 0, 16'h0000};
        vecs[1]  = '{16'h5010, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0010, 2, 1, 0, 16'h0000};
        vecs[2]  = '{16'h0902, 16'hFFFF, 16'h0001, 1, 0, 0, 0, 16'h0000, 16'h0011, 1, 1, 0, 16'h0000};
        vecs[3]  = '{16'h0902, 16'hFFFF, 16'h0001, 1, 0, 0, 1, 16'h8000, 16'h8011, 1, 1, 0, 16'h0000};
        vecs[4]  = '{16'h58FF, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 3, 1, 0, 16'h0000};
        vecs[5]  = '{16'h607F, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h007F, 4, 1, 0, 16'h0000};
        vecs[6]  = '{16'h2A01, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h007F, 5, 0, 1, 16'h1234};
        vecs[7]  = '{16'h0000, 16'h9999, 16'h9999, 0, 0, 0, 0, 16'h0000, 16'h007F, 5, 0, 0, 16'h1234};
        vecs[8]  = '{16'h2A01, 16'h0042, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h007F, 5, 0, 1, 16'h0042};
        vecs[9]  = '{16'h2A01, 16'h0043, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h007F, 5, 0, 1, 16'h0043};
        vecs[10] = '{16'h0902, 16'h0001, 16'h0001, 1, 0, 1, 0, 16'h0100, 16'h0101, 1, 1, 0, 16'h0043};
        vecs[11] = '{16'h5220, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0101, 1, 1, 0, 16'h0043};

        idle_inputs();
        RSTN = 1'b0;
        #12;
        check("rst_result", result_q, 16'h0000);
        check("rst_dr", {13'd0, dr_q}, 16'd0);
        check("rst_we", {15'd0, we_q}, 16'd0);
        check("rst_addr", mem_addr_q, 16'h0000);
        check("rst_re", {15'd0, mem_re_q}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        RSTN = 1'b1;
        step();

        // vecs[11] is li with ir[10:8]!=0: no-op, holds result/dr, drops we_q
        vecs[11].exp_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ir = vecs[i].ir; rs1_data = vecs[i].rs1; rs2_data = vecs[i].rs2;
            fwd_sr1 = vecs[i].f1; fwd_sr2 = vecs[i].f2;
            fwd_sr1_dr = vecs[i].f1dr; fwd_sr2_dr = vecs[i].f2dr;
            load_data = vecs[i].ldat; load = 1'b1;
            step();
            check($sformatf("v%0d_result", i), result_q, vecs[i].exp_res);
            check($sformatf("v%0d_dr", i), {13'd0, dr_q}, {13'd0, vecs[i].exp_dr});
            check($sformatf("v%0d_we", i), {15'd0, we_q}, {15'd0, vecs[i].exp_we});
            check($sformatf("v%0d_re", i), {15'd0, mem_re_q}, {15'd0, vecs[i].exp_re});
            check($sformatf("v%0d_addr", i), mem_addr_q, vecs[i].exp_addr);
        end

        // Stall: outputs hold, strobes drop
        idle_inputs();
        rs1_data = 16'h7777;
        step();
        check("stall_we", {15'd0, we_q}, 16'd0);
        check("stall_re", {15'd0, mem_re_q}, 16'd0);
        check("stall_result", result_q, 16'h0101);
        check("stall_addr", mem_addr_q, 16'h0043);

        do_mul(16'h0003, 16'h0005, 16'h000F, 16'h0101);
        do_mul(16'h0100, 16'h0100, 16'h0000, 16'h000F);
        do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);

        // Reset mid-multiply
        idle_inputs();
        ir = 16'h3143; rs1_data = 16'h0003; rs2_data = 16'h0005; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy_before_rst", {15'd0, busy}, 16'd1);
        #2;
        RSTN = 1'b0;
        #1;
        check("arst_busy", {15'd0, busy}, 16'd0);
        check("arst_result", result_q, 16'h0000);
        check("arst_dr", {13'd0, dr_q}, 16'd0);
        check("arst_we", {15'd0, we_q}, 16'd0);
        step();
        step();
        RSTN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (we_q) check("arst_no_write", {15'd0, we_q}, 16'd0);
            if (busy) check("arst_no_busy", {15'd0, busy}, 16'd0);
        end
        ir = 16'h0902; rs1_data = 16'h0003; rs2_data = 16'h0004; load = 1'b1;
        step();
        load = 1'b0;
        check("post_rst_add", result_q, 16'h0007);
        check("post_rst_we", {15'd0, we_q}, 16'd1);
        step();
        check("post_rst_we_drop", {15'd0, we_q}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipelined CPU, directly downstream of the forwarding unit.
- Consumes the registered bypass flags (sr1/sr2 = prior ALU result, sr1_dr/sr2_dr = prior load data) and selects operands.
- Executes add/li/ld/mul; mul is iterative with a busy stall.
- Produces the registered result, destination and write enable for writeback, plus the memory read request for ld.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle. Legal values 1, 2, 4. Mul iteration count N = 16/BITS_PER_CYCLE.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- load  in  1  pipeline advance; issues ir when not busy.
- ir  in  16  instruction in execute.
- rs1_data  in  16  register-file read of ir[10:8].
- rs2_data  in  16  register-file read of ir[7:5].
- fwd_sr1  in  1  operand A takes result_q.
- fwd_sr2  in  1  operand B takes result_q.
- fwd_sr1_dr  in  1  operand A takes load_data.
- fwd_sr2_dr  in  1  operand B takes load_data.
- load_data  in  16  memory read data for the previous ld.
- result_q  out  16  registered result.
- dr_q  out  3  registered destination register.
- we_q  out  1  register write strobe, one-cycle pulse.
- mem_addr_q  out  16  ld address.
- mem_re_q  out  1  memory read strobe, one-cycle pulse.
- busy  out  1  multiplier active; upstream must hold load=0.

Behaviour:
- Reset (async): result_q=0, dr_q=0, we_q=0, mem_addr_q=0, mem_re_q=0, busy=0, FSM=IDLE, multiplier regs=0. Reset asserted mid-mul aborts the multiply; no write occurs.
- Decode of ir:
  - ld: [15:14]=00 and [7:0]=0x01.
  - add: [15:14]=00 and [4:0]=00010.
  - mul: [15:14]=00 and [4:0]=00011.
  - li: [15:14]=01 and [10:8]=000.
  - nop: ir=0x0000. nop and all other encodings are no-op.
- Operand select (combinational):
  - A = fwd_sr1_dr ? load_data : fwd_sr1 ? result_q : rs1_data.
  - B = fwd_sr2_dr ? load_data : fwd_sr2 ? result_q : rs2_data.
  - The _dr flag wins if both flags of a pair are set.
- FSM states: IDLE, MUL.
- IDLE, load=1 (issue edge); dr_q<=ir[13:11] for every issued op:
  - add: result_q<=(A+B) mod 2^16; we_q<=1. Latency 1 cycle.
  - li: result_q<=sign-extend(ir[7:0]); we_q<=1.
  - ld: mem_addr_q<=A; mem_re_q<=1; we_q<=0. Writeback takes load_data next stage.
  - mul: latch multiplicand=A, multiplier=B; acc<=0; cnt<=0; busy<=1; go MUL; we_q<=0.
  - no-op: we_q<=0, mem_re_q<=0. result_q and dr_q hold.
- IDLE, load=0:
  - we_q<=0, mem_re_q<=0.
  - result_q, dr_q, mem_addr_q hold, so bypass stays valid across stalls.
- MUL, each cycle:
  - Retire BITS_PER_CYCLE multiplier LSBs, shift-add into acc, all mod 2^16; cnt+=1.
  - On the edge where cnt reaches N: result_q<=low 16 bits of the product; we_q<=1 for one cycle; busy<=0; go IDLE.
  - Total: busy high exactly N cycles; we_q pulses on the cycle after busy falls.
- load=1 while busy: ignored, with no state change.
- result_q is not updated during MUL, so forwarding to the multiply's consumer is valid only after completion.
- Back-to-back issues with load held high:
  - we_q stays 1 across consecutive writing ops.
  - mem_re_q stays 1 only across consecutive ld.

Test Plan:
- add (ir=0x0902: dr=1, sr1=1, sr2=0), rs1=0x0003, rs2=0x0004, no fwd, load=1 -> next edge result_q=0x0007, dr_q=1, we_q=1; following cycle with load=0 gives we_q=0.
- Previous result_q=0x0010, then add with fwd_sr1=1, rs1=0xFFFF, rs2=0x0001 -> result_q=0x0011. Repeat with fwd_sr2_dr=1 and load_data=0x8000, plus fwd_sr1=1 -> A=0x0011, result_q=0x8011.
- li with ir[7:0]=0xFF -> result_q=0xFFFF; with ir[7:0]=0x7F -> 0x007F.
- ld with A=0x1234 -> mem_addr_q=0x1234, mem_re_q=1 for one cycle, we_q=0.
- mul A=0x0003, B=0x0005, BITS_PER_CYCLE=1:
  - busy high 16 cycles; load pulses during busy are ignored.
  - Then result_q=0x000F with a one-cycle we_q.
  - A=0x0100, B=0x0100 -> 0x0000.
  - A=0xFFFF, B=0xFFFF -> 0x0001.
  - BITS_PER_CYCLE=4 -> busy high 4 cycles.
- Mul issued, RSTN low at cycle 5 -> all outputs 0 immediately, busy=0, no we_q. After release, an add issues normally.
